// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types and sizes for the round-robin grant scheduler.
package rr_grant_scheduler_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Requester-side bus of the grant scheduler; release is carried as
// release_in because the bare word is a reserved keyword.
interface rr_grant_scheduler_if;
   import rr_grant_scheduler_pkg::*;

   logic [N_REQ-1:0] req;
   logic             release_in;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req,
      output release_in,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  release_in,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );

endinterface

// File: rtl/rr_grant_scheduler_idx_to_onehot.sv
// Combinational binary index to one-hot select decode.
module rr_grant_scheduler_idx_to_onehot
   import rr_grant_scheduler_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter for 8 requesters with bounded hold time and
// rotating priority after every grant.
module rr_grant_scheduler
   import rr_grant_scheduler_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input logic                 clk,
   input logic                 rst,
   rr_grant_scheduler_if.slave bus
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [IDX_W-1:0]   off;
   logic [IDX_W-1:0]   winner;
   logic [N_REQ-1:0]   win_oh;

   // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
   assign req_dbl = {bus.req, bus.req};
   assign req_rot = req_dbl[ptr_q +: N_REQ];

   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) off = IDX_W'(i);
      end
      winner = ptr_q + off;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               idx_d   = winner;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.release_in || !bus.req[idx_q]) begin
               ptr_d   = idx_q + IDX_W'(1);
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               ptr_d     = idx_q + IDX_W'(1);
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   rr_grant_scheduler_idx_to_onehot u_dec (
      .idx    (idx_d),
      .onehot (win_oh)
   );

   assign gnt_d = (state_d == GRANT) ? win_oh : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed and random checks of rr_grant_scheduler against a
// cycle-level behavioural model of the arbitration rules.
module tb_rr_grant_scheduler;

   localparam int MAX_HOLD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_s = 8'h00;
   logic       rel_s = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   rr_grant_scheduler_if bus ();

   assign bus.req        = req_s;
   assign bus.release_in = rel_s;

   rr_grant_scheduler #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: owner is -1 when idle; age counts visible grant cycles.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_last  = 0;
   int         m_age   = 0;
   bit         m_to    = 0;

   always @(posedge clk) begin
      logic [7:0] r;
      logic       rl;
      logic       rs;
      r  = req_s;
      rl = rel_s;
      rs = rst;
      m_to = 0;
      if (rs) begin
         m_owner = -1;
         m_ptr   = 0;
         m_last  = 0;
         m_age   = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (m_owner < 0 && r[c]) begin
               m_owner = c;
               m_last  = c;
               m_age   = 1;
            end
         end
      end else if (rl || !r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
      end else if (m_age == MAX_HOLD) begin
         m_to    = 1;
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
      end else begin
         m_age++;
      end
      #1;
      chk("gnt", {24'h0, bus.gnt},
          (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
      chk("gnt_valid", {31'h0, bus.gnt_valid},
          (m_owner >= 0) ? 32'h1 : 32'h0);
      chk("timeout", {31'h0, bus.timeout}, {31'h0, m_to});
      chk("gnt_idx", {29'h0, bus.gnt_idx}, m_last);
   end

   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      int held;
      int guard;
      logic [7:0] exp_g;

      // Reset held two cycles with all requesting
      req_s = 8'hFF;
      rst   = 1'b1;
      nxt();
      nxt();
      chk("rst_gnt", {24'h0, bus.gnt}, 32'h00);
      chk("rst_idx", {29'h0, bus.gnt_idx}, 32'h0);
      chk("rst_valid", {31'h0, bus.gnt_valid}, 32'h0);
      chk("rst_to", {31'h0, bus.timeout}, 32'h0);
      rst = 1'b0;
      nxt();
      chk("first_gnt", {24'h0, bus.gnt}, 32'h01);
      chk("first_idx", {29'h0, bus.gnt_idx}, 32'h0);

      // Full rotation with one-cycle grants
      for (int k = 0; k < 8; k++) begin
         exp_g = 8'h01 << k;
         chk("rot_gnt", {24'h0, bus.gnt}, {24'h0, exp_g});
         chk("rot_idx", {29'h0, bus.gnt_idx}, k);
         rel_s = 1'b1;
         nxt();
         chk("rot_gap", {24'h0, bus.gnt}, 32'h00);
         rel_s = 1'b0;
         nxt();
      end
      chk("rot_wrap", {24'h0, bus.gnt}, 32'h01);

      // Pointer wrap from 7 to 0
      req_s = 8'h40;
      rel_s = 1'b1;
      nxt();
      rel_s = 1'b0;
      nxt();
      chk("own6", {24'h0, bus.gnt}, 32'h40);
      req_s = 8'h81;
      rel_s = 1'b1;
      nxt();
      rel_s = 1'b0;
      nxt();
      chk("own7", {24'h0, bus.gnt}, 32'h80);
      rel_s = 1'b1;
      nxt();
      rel_s = 1'b0;
      nxt();
      chk("own0", {24'h0, bus.gnt}, 32'h01);

      // Forced revoke after MAX_HOLD cycles
      req_s = 8'h04;
      guard = 0;
      while (bus.gnt !== 8'h04 && guard < 5) begin
         nxt();
         guard++;
      end
      chk("hold_start", {24'h0, bus.gnt}, 32'h04);
      held = 0;
      while (bus.gnt === 8'h04 && held < 40) begin
         held++;
         nxt();
      end
      chk("hold_len", held, MAX_HOLD);
      chk("to_pulse", {31'h0, bus.timeout}, 32'h1);
      nxt();
      chk("to_drop", {31'h0, bus.timeout}, 32'h0);
      chk("regrant", {24'h0, bus.gnt}, 32'h04);

      // Release on the last allowed cycle beats the timeout
      repeat (MAX_HOLD - 1) nxt();
      chk("last_cyc", {24'h0, bus.gnt}, 32'h04);
      rel_s = 1'b1;
      nxt();
      chk("rel_win_gnt", {24'h0, bus.gnt}, 32'h00);
      chk("rel_win_to", {31'h0, bus.timeout}, 32'h0);
      rel_s = 1'b0;

      // Reset in the middle of a grant
      req_s = 8'h10;
      nxt();
      chk("mid_gnt", {24'h0, bus.gnt}, 32'h10);
      nxt();
      rst   = 1'b1;
      req_s = 8'hFF;
      nxt();
      chk("mid_rst_gnt", {24'h0, bus.gnt}, 32'h00);
      chk("mid_rst_to", {31'h0, bus.timeout}, 32'h0);
      rst = 1'b0;
      nxt();
      chk("post_rst", {24'h0, bus.gnt}, 32'h01);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 299) == 0);
         rel_s = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 15) == 0)
            req_s = 8'($urandom_range(0, 255));
         else if ($urandom_range(0, 63) == 0)
            req_s = 8'h00;
         nxt();
      end

      nxt();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
